ldm_stm_seq: RTL and testbench
==============================

# ldm_stm_seq

Multi-cycle load/store-multiple sequencer for the ARM datapath. Given a 16-bit register list, a base address and a direction, it walks the list from r0 to r15. For STM it reads each register through a regfile read port and writes it to memory. For LDM it reads memory and drives the regfile write port (we3/wa3/wd3) for each register. It sits between the controller, which issues the start pulse, the register file and the data-memory request/ack interface.

## Interface
Parameters:
- AW, 32, memory address width; must be ≥ 3.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM; sampled with start
- base_addr  in  AW  first transfer address (increment-after); sampled with start
- reg_list  in  16  bit i set = transfer ri; sampled with start
- busy  out  1  high while not IDLE
- done  out  1  one-cycle completion pulse
- final_addr  out  AW  base_addr + 4·popcount(reg_list); valid while done = 1, held until next start
- ra  out  4  regfile read address (STM data source)
- rd  in  32  regfile read data for ra (combinational; r15 returns PC+8)
- we3  out  1  regfile write enable
- wa3  out  4  regfile write address
- wd3  out  32  regfile write data
- pc_wr  out  1  LDM of r15: load PC with wd3 instead of regfile write
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store
- mem_addr  out  AW  word address of current transfer
- mem_wdata  out  32  store data
- mem_ack  in  1  request accepted/completed this cycle
- mem_rdata  in  32  load data, valid when mem_ack = 1

## Operation
Registered state: state, remaining list (16), current address (AW), direction, final_addr.

The current index i is the lowest set bit of the remaining list. This is a combinational priority encode.

States:
- IDLE
  - start = 1 latches list, address and direction; final_addr ← base_addr + (popcount << 2).
  - If reg_list = 0, go to DONE; otherwise go to XFER.
- XFER
  - mem_req = 1; mem_we = ~dir_load; mem_addr = current address; ra = i; mem_wdata = rd.
  - Request fields stay constant until mem_ack is high.
  - On mem_ack:
    - Load with i ≠ 15: we3 = 1, wa3 = i, wd3 = mem_rdata in that same cycle.
    - Load with i = 15: pc_wr = 1, wd3 = mem_rdata, we3 = 0.
    - Clear bit i; address ← address + 4, wrapping modulo 2^AW.
    - If the list becomes 0, go to DONE.
- DONE
  - done = 1 for exactly one cycle, then IDLE. busy = 1 in DONE.

Behaviour outside XFER:
- we3, pc_wr and mem_req are 0 in all states except XFER.
- In XFER, we3 and pc_wr are asserted only in the cycle mem_ack = 1.
- When idle, ra, wa3, wd3, mem_addr and mem_wdata are don't-care but must be driven. Drive them to 0.

Boundary rules:
- start while busy: ignored.
- mem_ack while mem_req = 0: ignored.
- Address wrap past 2^AW − 4 continues at 0.
- Register writes occur only on acked load beats; no other writes.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - busy, done, mem_req, mem_we, we3 and pc_wr = 0.
  - final_addr, mem_addr, wa3, wd3, ra and mem_wdata = 0.
- Reset during XFER:
  - mem_req and we3 drop asynchronously.
  - The partially walked list is discarded.
  - No done is produced.
- Start → first mem_req: 1 cycle (request is visible in the cycle after start).
- With zero-wait memory (mem_ack tied high during XFER):
  - N set bits → N XFER cycles + 1 DONE cycle.
  - done rises N+1 cycles after start.
- Each wait cycle (mem_req = 1, mem_ack = 0) adds exactly one cycle and changes no output.
- Empty list: done in the cycle after start, with no memory or regfile activity.
- Back-to-back: start sampled in the cycle after DONE (state IDLE) is accepted.

## Test plan
- STM, reg_list = 0x0013, base = 0x100, r0/r1/r4 = 0xA/0xB/0xC, ack always high → stores:
  - (0x100, 0xA), (0x104, 0xB), (0x110? no) (0x108, 0xC);
  - done 4 cycles after start; final_addr = 0x10C.
- LDM, reg_list = 0x8006, base = 0x200, mem returns 0x11/0x22/0x33:
  - we3 to r1 = 0x11, then r2 = 0x22;
  - pc_wr with 0x33 and we3 = 0 on the third beat;
  - final_addr = 0x20C.
- LDM of a single register with mem_ack delayed 3 cycles → mem_addr/mem_req held stable for 4 cycles, we3 pulses once, done 5 cycles after start.
- reg_list = 0x0000 → done the cycle after start; mem_req and we3 never asserted; final_addr = base.
- STM, base = 0xFFFF_FFFC, reg_list = 0x0003 → addresses 0xFFFF_FFFC then 0x0000_0000; final_addr = 0x4.
- reset_n low during the second beat of a 4-register LDM:
  - all outputs go to reset values immediately;
  - no further we3;
  - a new start after release completes normally.

Source files
------------

// File: rtl/ldm_stm_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ldm_stm_seq                                                 |
// | Description : Multi-cycle load/store-multiple sequencer. Walks a 16-bit   |
// |               register list from r0 to r15. STM reads the regfile and     |
// |               stores to memory. LDM loads from memory and writes the      |
// |               regfile, or the PC for r15. The address increments by 4     |
// |               after each transfer.                                        |
// | Ports       : clk, reset_n            - clock, async active-low reset     |
// |               start/is_load/base_addr/reg_list - request, sampled in IDLE |
// |               busy, done, final_addr  - status and writeback base         |
// |               ra, rd                  - regfile read port (STM data)      |
// |               we3, wa3, wd3, pc_wr    - regfile / PC write port (LDM)     |
// |               mem_req/we/addr/wdata, mem_ack, mem_rdata - memory handshake|
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module ldm_stm_seq #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          is_load,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   reg_list,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] final_addr,
  output logic [3:0]    ra,
  input  logic [31:0]   rd,
  output logic          we3,
  output logic [3:0]    wa3,
  output logic [31:0]   wd3,
  output logic          pc_wr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     list_q, list_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic            dir_load;
  logic [AW-1:0]   final_q;
  logic [3:0]      idx;
  logic [4:0]      pop;

  // Lowest set bit of the remaining list: scanning downward lets the
  // lowest match overwrite any higher one.
  always_comb begin
    idx = 4'd0;
    for (int b = 15; b >= 0; b--) begin
      if (list_q[b]) idx = 4'(b);
    end
  end

  always_comb begin
    pop = 5'd0;
    for (int b = 0; b < 16; b++) begin
      pop = pop + 5'(reg_list[b]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      list_q   <= 16'd0;
      addr_q   <= '0;
      dir_load <= 1'b0;
      final_q  <= '0;
    end else begin
      state  <= state_nxt;
      list_q <= list_nxt;
      addr_q <= addr_nxt;
      if (state == IDLE && start) begin
        dir_load <= is_load;
        final_q  <= base_addr + (AW'(pop) << 2);
      end
    end
  end

  // Outputs decode from the registered state only, so an asynchronous
  // reset drops mem_req/we3 immediately.
  always_comb begin
    state_nxt = state;
    list_nxt  = list_q;
    addr_nxt  = addr_q;
    ra        = 4'd0;
    we3       = 1'b0;
    wa3       = 4'd0;
    wd3       = 32'd0;
    pc_wr     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;

    case (state)
      IDLE: begin
        if (start) begin
          list_nxt  = reg_list;
          addr_nxt  = base_addr;
          state_nxt = (reg_list == 16'd0) ? DONE : XFER;
        end
      end
      XFER: begin
        mem_req   = 1'b1;
        mem_we    = ~dir_load;
        mem_addr  = addr_q;
        ra        = idx;
        mem_wdata = rd;
        if (dir_load) wa3 = idx;
        if (mem_ack) begin
          if (dir_load) begin
            wd3 = mem_rdata;
            if (idx == 4'd15) pc_wr = 1'b1;
            else              we3   = 1'b1;
          end
          list_nxt = list_q & ~(16'd1 << idx);
          addr_nxt = addr_q + AW'(4);
          if (list_nxt == 16'd0) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign final_addr = final_q;

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ldm_stm_seq                                              |
// | Description : Self-checking bench for ldm_stm_seq. Directed scenarios     |
// |               plus randomized transactions, checked against a transfer-   |
// |               list reference model with a behavioural regfile and PC.     |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_ldm_stm_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_load;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic        busy;
  logic        done;
  logic [31:0] final_addr;
  logic [3:0]  ra;
  logic [31:0] rd;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        pc_wr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] regs [16];
  logic [31:0] pc;
  logic [31:0] prev_final;

  ldm_stm_seq #(.AW(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load),
    .base_addr(base_addr), .reg_list(reg_list), .busy(busy), .done(done),
    .final_addr(final_addr), .ra(ra), .rd(rd), .we3(we3), .wa3(wa3),
    .wd3(wd3), .pc_wr(pc_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural regfile read port: r15 reads as PC+8.
  always_comb rd = (ra == 4'd15) ? pc + 32'd8 : regs[ra];

  function automatic logic [31:0] exp_rd(input int i);
    return (i == 15) ? pc + 32'd8 : regs[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd0);
    chk({tag, "_req"},     32'(mem_req), 32'd0);
    chk({tag, "_we"},      32'(mem_we), 32'd0);
    chk({tag, "_we3"},     32'(we3), 32'd0);
    chk({tag, "_pcwr"},    32'(pc_wr), 32'd0);
    chk({tag, "_addr"},    mem_addr, 32'd0);
    chk({tag, "_ra"},      32'(ra), 32'd0);
    chk({tag, "_wa3"},     32'(wa3), 32'd0);
    chk({tag, "_wd3"},     wd3, 32'd0);
    chk({tag, "_wdata"},   mem_wdata, 32'd0);
  endtask

  // One complete transaction. maxwait bounds the random ack delay per beat;
  // fixed_wait >= 0 forces that delay on every beat instead.
  task automatic run_txn(input bit load, input logic [31:0] base,
                         input logic [15:0] list, input int maxwait,
                         input int fixed_wait, input logic [31:0] exp_final);
    logic [31:0] addr;
    logic [31:0] rdat;
    int waits;
    // IDLE cycle carrying the start request (also the back-to-back case).
    @(negedge clk);
    start = 1'b1; is_load = load; base_addr = base; reg_list = list;
    mem_ack = $urandom_range(0, 1); mem_rdata = $urandom;
    #1;
    chk_idle_outputs("idle");
    chk("final_held", final_addr, prev_final);
    addr = base;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        waits = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, maxwait));
        rdat  = $urandom;
        for (int w = 0; w <= waits; w++) begin
          @(negedge clk);
          // Fresh start/inputs while busy must be ignored.
          start = $urandom_range(0, 1); is_load = $urandom_range(0, 1);
          base_addr = $urandom; reg_list = $urandom;
          mem_ack   = (w == waits);
          mem_rdata = (w == waits) ? rdat : $urandom;
          #1;
          chk("req",  32'(mem_req), 32'd1);
          chk("busy", 32'(busy), 32'd1);
          chk("done", 32'(done), 32'd0);
          chk("addr", mem_addr, addr);
          chk("mwe",  32'(mem_we), 32'(!load));
          if (!load) begin
            chk("ra",    32'(ra), 32'(i));
            chk("wdata", mem_wdata, exp_rd(i));
          end
          if (load && w == waits) begin
            chk("we3",  32'(we3), 32'(i != 15));
            chk("pcwr", 32'(pc_wr), 32'(i == 15));
            chk("wd3",  wd3, rdat);
            if (i != 15) chk("wa3", 32'(wa3), 32'(i));
          end else begin
            chk("we3_quiet",  32'(we3), 32'd0);
            chk("pcwr_quiet", 32'(pc_wr), 32'd0);
          end
        end
        if (load) begin
          if (i == 15) pc = rdat;
          else         regs[i] = rdat;
        end
        addr = addr + 32'd4;
      end
    end
    // DONE cycle.
    @(negedge clk);
    start = $urandom_range(0, 1); mem_ack = $urandom_range(0, 1);
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy",  32'(busy), 32'd1);
    chk("done_req",   32'(mem_req), 32'd0);
    chk("done_we3",   32'(we3), 32'd0);
    chk("final",      final_addr, exp_final);
    prev_final = exp_final;
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] rl;
    logic [31:0] rb;
    bit          rload;
    reset_n = 1'b0; start = 1'b0; is_load = 1'b0; base_addr = 32'd0;
    reg_list = 16'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    pc = 32'h0000_8000; prev_final = 32'd0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[0] = 32'hA; regs[1] = 32'hB; regs[4] = 32'hC;

    #3;
    chk_idle_outputs("reset");
    chk("reset_final", final_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // STM r0,r1,r4 from 0x100, zero-wait.
    run_txn(1'b0, 32'h100, 16'h0013, 0, 0, 32'h10C);
    // LDM r1,r2,r15 from 0x200.
    run_txn(1'b1, 32'h200, 16'h8006, 0, 0, 32'h20C);
    // Single-register LDM with a 3-cycle ack delay.
    run_txn(1'b1, 32'h040, 16'h0100, 0, 3, 32'h044);
    // Empty list.
    run_txn(1'b0, 32'h1234, 16'h0000, 0, 0, 32'h1234);
    // Address wrap.
    run_txn(1'b0, 32'hFFFF_FFFC, 16'h0003, 0, 0, 32'h4);

    // Reset in the second beat of a 4-register LDM.
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; base_addr = 32'h300; reg_list = 16'h00F0;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_0004;
    #1;
    chk("rst_beat1_we3", 32'(we3), 32'd1);
    chk("rst_beat1_wa3", 32'(wa3), 32'd4);
    regs[4] = 32'h5555_0004;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rst_beat2_addr", mem_addr, 32'h304);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_final", final_addr, 32'd0);
    prev_final = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      chk("rst_hold_we3",  32'(we3), 32'd0);
      chk("rst_hold_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1; mem_ack = 1'b0;
    run_txn(1'b1, 32'h400, 16'h0021, 1, -1, 32'h408);

    // Randomized transactions with random ack delays.
    for (int t = 0; t < 16; t++) begin
      rload = $urandom_range(0, 1);
      rb    = $urandom & 32'hFFFF_FFFC;
      if (t % 5 == 0) rb = 32'hFFFF_FFF0;
      rl    = (t % 7 == 3) ? 16'h0000 : 16'($urandom);
      run_txn(rload, rb, rl, 2, -1, rb + 32'd4 * 32'($countones(rl)));
    end

    @(negedge clk);
    #1;
    chk("final_idle_busy", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
